// File: rtl/parity_nibble_rx_pkg.sv
// Shared types and helpers for the nibble-with-parity serial receiver.
package parity_nibble_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Width of a counter that must hold 0..clks-1.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/parity_nibble_rx_sync2.sv
// Two-flop synchroniser for a single asynchronous bit; resets to ResetVal.
module parity_nibble_rx_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/parity_nibble_rx.sv
// Serial receiver: start, DATA_BITS data (LSB first), parity, stop; mid-bit sampling.
// Define PARITY_NIBBLE_RX_ODD_EN to check odd instead of even parity.
module parity_nibble_rx
  import parity_nibble_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam int unsigned IdxW = cnt_width(DATA_BITS);

  localparam logic [CntW-1:0] HalfM1  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitM1   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  logic rx_s;

  parity_nibble_rx_sync2 #(
    .ResetVal (IDLE_LEVEL)
  ) u_sync2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx_in),
    .q_o    (rx_s)
  );

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 valid_q, valid_d;

  logic tick;
  logic perr_calc;

  assign tick = (cnt_q == BitM1);

`ifdef PARITY_NIBBLE_RX_ODD_EN
  assign perr_calc = ~(acc_q ^ rx_s);
`else
  assign perr_calc = acc_q ^ rx_s;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    perr_d       = perr_q;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    valid_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (rx_s == START_LEVEL) begin
          state_d = StStart;
          cnt_d   = '0;
          idx_d   = '0;
          acc_d   = 1'b0;
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          // A start bit that is gone by mid-bit was a glitch.
          state_d = (rx_s == START_LEVEL) ? StData : StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          acc_d          = acc_q ^ rx_s;
          if (idx_q == LastIdx) begin
            state_d = StParity;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = perr_calc;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (tick) begin
          cnt_d        = '0;
          data_out_d   = shift_q;
          parity_err_d = perr_q;
          frame_err_d  = (rx_s != IDLE_LEVEL);
          valid_d      = 1'b1;
          // A low stop bit may be a break; wait for the line to return high.
          state_d      = (rx_s == IDLE_LEVEL) ? StIdle : StWaitIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitIdle: begin
        if (rx_s == IDLE_LEVEL) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      perr_q       <= 1'b0;
      data_out_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      perr_q       <= perr_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      valid_q      <= valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_parity_nibble_rx.sv
// Scoreboard bench for parity_nibble_rx: directed frames, monitor checks each valid strobe.
module tb_parity_nibble_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [3:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  parity_nibble_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   vt[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected flags below are written for even parity; the odd build flips parity_err.
  function automatic logic adj(input logic even_perr);
`ifdef PARITY_NIBBLE_RX_ODD_EN
    return ~even_perr;
`else
    return even_perr;
`endif
  endfunction

  task automatic push(input logic [3:0] d, input logic even_perr, input logic ferr);
    exp_t e;
    e.data = d;
    e.perr = adj(even_perr);
    e.ferr = ferr;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      vt.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {31'b0, valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_out", {28'b0, data_out}, {28'b0, e.data});
        chk("parity_err", {31'b0, parity_err}, {31'b0, e.perr});
        chk("frame_err", {31'b0, frame_err}, {31'b0, e.ferr});
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rx_in    = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", {28'b0, data_out}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_parity_err", {31'b0, parity_err}, 32'd0);
    chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Clean frame 0xA.
    push(4'hA, 1'b0, 1'b0);
    send_frame(4'hA, 1'b0, 1'b1);
    wait_drain();
    repeat (20) @(negedge clk);
    chk("a_busy_after", {31'b0, busy}, 32'd0);
    chk("a_data_held", {28'b0, data_out}, 32'hA);

    // Bad parity on 0x7, then a good 0x5 clears the flag.
    push(4'h7, 1'b1, 1'b0);
    send_frame(4'h7, 1'b0, 1'b1);
    wait_drain();
    chk("perr_held", {31'b0, parity_err}, {31'b0, adj(1'b1)});
    push(4'h5, 1'b0, 1'b0);
    send_frame(4'h5, 1'b0, 1'b1);
    wait_drain();
    repeat (10) @(negedge clk);

    // Short glitch: enters START, rejected at mid-bit.
    rx_in = 1'b0;
    repeat (5) @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", {31'b0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    chk("glitch_busy_lo", {31'b0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    // Frame 0x3 with low stop bit and a 3-bit-time break.
    push(4'h3, 1'b0, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i < 2 ? 1'b1 : 1'b0);
    send_bit(1'b0);
    rx_in = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("break_busy_hi", {31'b0, busy}, 32'd1);
    chk("break_ferr", {31'b0, frame_err}, 32'd1);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_busy_lo", {31'b0, busy}, 32'd0);
    wait_drain();
    repeat (20) @(negedge clk);

    // Reset during DATA of 0xC, then a clean 0x9.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_data", {28'b0, data_out}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push(4'h9, 1'b0, 1'b0);
    send_frame(4'h9, 1'b0, 1'b1);
    wait_drain();
    repeat (20) @(negedge clk);

    // Back-to-back 0xF and 0x1 with no idle gap.
    push(4'hF, 1'b0, 1'b0);
    push(4'h1, 1'b0, 1'b0);
    send_frame(4'hF, 1'b0, 1'b1);
    send_frame(4'h1, 1'b1, 1'b1);
    wait_drain();
    if (vt.size() >= 2) chk("b2b_gap", vt[vt.size()-1] - vt[vt.size()-2], 7 * CPB);
    else chk("b2b_valid_seen", vt.size(), 32'd7);
    repeat (20) @(negedge clk);
    chk("valid_count", vt.size(), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
